// File: rtl/commit_trace_fifo.sv
// First-word-fall-through trace FIFO for architectural commits (GRF and DM writes).
// Up to two events are accepted per cycle, GRF first. Lost events are counted, never overwritten.
module commit_trace_fifo #(
   parameter int AW     = 4,
   parameter int DROP_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_trace_en,
   input  logic [31:0]       i_pc,
   input  logic              i_grf_we,
   input  logic [4:0]        i_grf_addr,
   input  logic [31:0]       i_grf_wdata,
   input  logic              i_dm_we,
   input  logic [31:0]       i_dm_addr,
   input  logic [31:0]       i_dm_wdata,
   input  logic              i_trc_ready,
   output logic              o_trc_valid,
   output logic              o_trc_kind,
   output logic [31:0]       o_trc_pc,
   output logic [31:0]       o_trc_addr,
   output logic [31:0]       o_trc_data,
   output logic [AW:0]       o_count,
   output logic              o_overflow,
   output logic [DROP_W-1:0] o_drop_cnt
);
   localparam int DEPTH = 1 << AW;

   // Entry layout: {kind, pc, addr, data}
   logic [96:0]       r_mem [DEPTH];
   logic [AW-1:0]     r_rd_ptr;
   logic [AW-1:0]     r_wr_ptr;
   logic [AW:0]       r_count;
   logic              r_overflow;
   logic [DROP_W-1:0] r_drop_cnt;

   logic              w_g;
   logic              w_d;
   logic              w_pop;
   logic [AW+1:0]     w_free;
   logic              w_acc_g;
   logic              w_acc_d;
   logic [1:0]        w_n_push;
   logic [1:0]        w_n_drop;
   logic [DROP_W:0]   w_drop_sum;
   logic [AW-1:0]     w_dm_ptr;
   logic [96:0]       w_head;
   logic [96:0]       w_grf_entry;
   logic [96:0]       w_dm_entry;

   assign w_g   = i_trace_en & i_grf_we & (i_grf_addr != 5'd0);
   assign w_d   = i_trace_en & i_dm_we;
   assign w_pop = o_trc_valid & i_trc_ready;

   // A same-cycle pop makes room for one more push.
   assign w_free  = (AW+2)'(DEPTH) - {1'b0, r_count} + (AW+2)'(w_pop);
   assign w_acc_g = w_g & (w_free != '0);
   assign w_acc_d = w_d & (w_free > (AW+2)'(w_acc_g));

   assign w_n_push   = 2'(w_acc_g) + 2'(w_acc_d);
   assign w_n_drop   = 2'(w_g & ~w_acc_g) + 2'(w_d & ~w_acc_d);
   assign w_drop_sum = {1'b0, r_drop_cnt} + (DROP_W+1)'(w_n_drop);
   assign w_dm_ptr   = w_acc_g ? r_wr_ptr + AW'(1) : r_wr_ptr;

   assign w_grf_entry = {1'b0, i_pc, 27'd0, i_grf_addr, i_grf_wdata};
   assign w_dm_entry  = {1'b1, i_pc, i_dm_addr, i_dm_wdata};

   always_ff @(posedge i_clk) begin
      if (w_acc_g) r_mem[r_wr_ptr] <= w_grf_entry;
      if (w_acc_d) r_mem[w_dm_ptr] <= w_dm_entry;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         r_wr_ptr <= r_wr_ptr + AW'(w_n_push);
         r_rd_ptr <= r_rd_ptr + AW'(w_pop);
         r_count  <= r_count + (AW+1)'(w_n_push) - (AW+1)'(w_pop);
         if (w_n_drop != 2'd0) begin
            r_overflow <= 1'b1;
            r_drop_cnt <= w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
         end
      end
   end

   assign w_head      = r_mem[r_rd_ptr];
   assign o_trc_valid = (r_count != '0);
   // Head fields are gated so an empty FIFO never exposes stale storage.
   assign o_trc_kind  = o_trc_valid & w_head[96];
   assign o_trc_pc    = o_trc_valid ? w_head[95:64] : 32'd0;
   assign o_trc_addr  = o_trc_valid ? w_head[63:32] : 32'd0;
   assign o_trc_data  = o_trc_valid ? w_head[31:0]  : 32'd0;
   assign o_count     = r_count;
   assign o_overflow  = r_overflow;
   assign o_drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_commit_trace_fifo.sv
// Scoreboard bench for commit_trace_fifo: directed pushes queue expected entries,
// a negedge monitor checks every popped head against the queue.
module tb_commit_trace_fifo;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        trace_en = 1'b0;
   logic [31:0] pc = '0;
   logic        grf_we = 1'b0;
   logic [4:0]  grf_addr = '0;
   logic [31:0] grf_wdata = '0;
   logic        dm_we = 1'b0;
   logic [31:0] dm_addr = '0;
   logic [31:0] dm_wdata = '0;
   logic        trc_ready = 1'b0;
   logic        trc_valid;
   logic        trc_kind;
   logic [31:0] trc_pc;
   logic [31:0] trc_addr;
   logic [31:0] trc_data;
   logic [4:0]  count;
   logic        overflow;
   logic [7:0]  drop_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   logic [96:0] sb_q [$];

   commit_trace_fifo #(.AW(4), .DROP_W(8)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_trace_en(trace_en), .i_pc(pc),
      .i_grf_we(grf_we), .i_grf_addr(grf_addr), .i_grf_wdata(grf_wdata),
      .i_dm_we(dm_we), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
      .i_trc_ready(trc_ready), .o_trc_valid(trc_valid), .o_trc_kind(trc_kind),
      .o_trc_pc(trc_pc), .o_trc_addr(trc_addr), .o_trc_data(trc_data),
      .o_count(count), .o_overflow(overflow), .o_drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: a pop happens at the next posedge whenever valid&ready here.
   always @(negedge clk) begin
      if (rst_n && trc_valid && trc_ready) begin
         logic [96:0] act;
         logic [96:0] exp;
         act = {trc_kind, trc_pc, trc_addr, trc_data};
         n_cmp++;
         if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL pop_unexpected: got 0x%0h expected no entry", act);
         end else begin
            exp = sb_q.pop_front();
            if (act !== exp) begin
               n_bad++;
               $display("FAIL pop_entry: got 0x%0h expected 0x%0h", act, exp);
            end else
               $display("pop kind=%0d pc=%08h addr=%08h data=%08h", act[96], act[95:64], act[63:32], act[31:0]);
         end
      end
   end

   // One commit cycle; exp_g/exp_d mark events the DUT must accept.
   task automatic commit(input logic [31:0] p, input logic gw, input logic [4:0] ga,
                         input logic [31:0] gd, input logic dw, input logic [31:0] da,
                         input logic [31:0] dd, input logic exp_g, input logic exp_d);
      pc = p; grf_we = gw; grf_addr = ga; grf_wdata = gd;
      dm_we = dw; dm_addr = da; dm_wdata = dd;
      if (exp_g) sb_q.push_back({1'b0, p, 27'd0, ga, gd});
      if (exp_d) sb_q.push_back({1'b1, p, da, dd});
      @(posedge clk); #1;
      grf_we = 1'b0; dm_we = 1'b0;
   endtask

   task automatic drain(input string name);
      int budget;
      budget = 100;
      trc_ready = 1'b1;
      while (count != 0 && budget > 0) begin
         @(posedge clk); #1;
         budget--;
      end
      trc_ready = 1'b0;
      check({name, "_count"}, 64'(count), 64'd0);
      check({name, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
   endtask

   task automatic sync_reset();
      rst_n = 1'b0;
      sb_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      // 1: reset with random strobes
      trace_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         grf_we = 1'($urandom); grf_addr = 5'($urandom); grf_wdata = $urandom;
         dm_we = 1'($urandom); dm_addr = $urandom; dm_wdata = $urandom;
         trc_ready = 1'($urandom);
         @(posedge clk); #1;
      end
      check("rst_valid", 64'(trc_valid), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
      check("rst_drop", 64'(drop_cnt), 64'd0);
      check("rst_trc", {31'd0, trc_kind, trc_pc}, 64'd0);
      check("rst_trc2", {trc_addr, trc_data}, 64'd0);
      grf_we = 1'b0; dm_we = 1'b0; trc_ready = 1'b0;
      rst_n = 1'b1;

      // 2: single GRF commit, one-cycle latency
      commit(32'h3000, 1, 5'd1, 32'h1234, 0, 0, 0, 1, 0);
      check("t2_valid", 64'(trc_valid), 64'd1);
      check("t2_kind", 64'(trc_kind), 64'd0);
      check("t2_addr", 64'(trc_addr), 64'd1);
      check("t2_data", 64'(trc_data), 64'h1234);
      check("t2_pc", 64'(trc_pc), 64'h3000);
      trc_ready = 1'b1;
      @(posedge clk); #1;
      trc_ready = 1'b0;
      check("t2_valid_after_pop", 64'(trc_valid), 64'd0);

      // 3: $0 writes and disabled capture are not events
      commit(32'h3008, 1, 5'd0, 32'hFFFF, 0, 0, 0, 0, 0);
      check("t3_zero_count", 64'(count), 64'd0);
      check("t3_zero_drop", 64'(drop_cnt), 64'd0);
      trace_en = 1'b0;
      commit(32'h300C, 1, 5'd3, 32'h1, 1, 32'h20, 32'h2, 0, 0);
      trace_en = 1'b1;
      check("t3_dis_count", 64'(count), 64'd0);
      check("t3_dis_overflow", 64'(overflow), 64'd0);
      trc_ready = 1'b1;   // ready while empty has no effect
      @(posedge clk); #1;
      trc_ready = 1'b0;
      check("t3_empty_ready_count", 64'(count), 64'd0);

      // 4: dual event, GRF first
      commit(32'h3004, 1, 5'd2, 32'd5, 1, 32'h10, 32'd7, 1, 1);
      check("t4_count", 64'(count), 64'd2);
      drain("t4");

      // 5: fill to 16 across pointer wrap, then drop one DM
      for (int i = 0; i < 16; i++)
         commit(32'h3100 + 32'(i*4), 1, 5'(i+1), 32'hA000 + 32'(i), 0, 0, 0, 1, 0);
      commit(32'h3200, 0, 0, 0, 1, 32'h80, 32'h99, 0, 0);
      check("t5_full_count", 64'(count), 64'd16);
      check("t5_overflow", 64'(overflow), 64'd1);
      check("t5_drop", 64'(drop_cnt), 64'd1);
      drain("t5");

      // 5b: G+D at count 15 keeps GRF, drops DM
      sync_reset();
      for (int i = 0; i < 15; i++)
         commit(32'h3300 + 32'(i*4), 1, 5'(i+1), 32'hB000 + 32'(i), 0, 0, 0, 1, 0);
      check("t5b_count15", 64'(count), 64'd15);
      commit(32'h3400, 1, 5'd20, 32'hBEEF, 1, 32'h40, 32'hDEAD, 1, 0);
      check("t5b_count", 64'(count), 64'd16);
      check("t5b_overflow", 64'(overflow), 64'd1);
      check("t5b_drop", 64'(drop_cnt), 64'd1);

      // 6: full with pop frees one slot for a same-cycle push
      trc_ready = 1'b1;
      commit(32'h3500, 1, 5'd21, 32'hC0DE, 0, 0, 0, 1, 0);
      trc_ready = 1'b0;
      check("t6_count", 64'(count), 64'd16);
      check("t6_overflow", 64'(overflow), 64'd1);
      check("t6_drop", 64'(drop_cnt), 64'd1);
      for (int i = 0; i < 300; i++)
         commit(32'h3600, 0, 0, 0, 1, 32'h44, 32'(i), 0, 0);
      check("t6_drop_sat", 64'(drop_cnt), 64'd255);
      check("t6_count_full", 64'(count), 64'd16);

      // 6b: async reset mid-operation clears state without a clock edge
      trc_ready = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      trc_ready = 1'b0;
      check("t6b_count13", 64'(count), 64'd13);
      commit(32'h3700, 1, 5'd9, 32'h9, 0, 0, 0, 1, 0);
      #3;
      rst_n = 1'b0;
      sb_q.delete();
      #1;
      check("t6b_count", 64'(count), 64'd0);
      check("t6b_valid", 64'(trc_valid), 64'd0);
      check("t6b_overflow", 64'(overflow), 64'd0);
      check("t6b_drop", 64'(drop_cnt), 64'd0);
      check("t6b_trc", {trc_addr, trc_data}, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      commit(32'h3800, 1, 5'd7, 32'h77, 1, 32'h88, 32'h99, 1, 1);
      check("t6b_post_count", 64'(count), 64'd2);
      drain("t6b");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
